// File: rtl/adc_axis_framer.sv
// ADC sample framer: cuts the gearboxed 4-SPC IQ stream into spp-word packets
// and buffers them in a first-word-fall-through FIFO feeding an AXI4-Stream master.
module adc_axis_framer #(
    parameter int FIFO_AW = 4
) (
    input  logic         clk2x,
    input  logic         reset_n_2x,
    input  logic [127:0] adc_in_2x,
    input  logic         valid_in_2x,
    input  logic         enable_2x,
    input  logic [15:0]  spp_2x,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    output logic         m_axis_tlast,
    input  logic         m_axis_tready,
    output logic         overflow_2x,
    output logic [15:0]  overflow_count_2x,
    input  logic         clear_count_2x
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   OVF_OCC = (FIFO_AW + 1)'(DEPTH - 2);
    localparam logic [FIFO_AW-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, OVERFLOW} state_t;

    state_t state, state_nxt;

    logic [15:0]        word_cnt;
    logic [15:0]        spp_lat;
    logic [15:0]        spp_sel;
    logic [128:0]       mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   mem_cnt;
    logic [FIFO_AW:0]   occ;
    logic               last_nat;
    logic               ovf_hit;
    logic               fifo_empty;
    logic               load_out;
    logic               wr_en;
    logic               wr_last;
    logic               ovf_event;
    logic               cnt_clear;
    logic               spp_load;

    assign spp_sel    = (spp_2x == 16'd0) ? 16'd1 : spp_2x;
    // Occupancy counts the output register too, so it is the number of words not yet transferred.
    assign occ        = mem_cnt + {{FIFO_AW{1'b0}}, m_axis_tvalid};
    assign fifo_empty = (occ == '0);
    assign last_nat   = (word_cnt == spp_lat - 16'd1);
    // A write at this occupancy fills to the threshold; it closes the packet and stops input.
    assign ovf_hit    = (occ == OVF_OCC);
    assign load_out   = (mem_cnt != '0) && (!m_axis_tvalid || m_axis_tready);

    always_ff @(posedge clk2x or negedge reset_n_2x) begin
        if (!reset_n_2x) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable_2x) state_nxt = RUN;
            end
            RUN: begin
                if (valid_in_2x) begin
                    if (ovf_hit)                    state_nxt = OVERFLOW;
                    else if (last_nat && !enable_2x) state_nxt = IDLE;
                end
            end
            OVERFLOW: begin
                if (fifo_empty) state_nxt = enable_2x ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_last   = 1'b0;
        ovf_event = 1'b0;
        cnt_clear = 1'b0;
        spp_load  = 1'b0;
        case (state)
            IDLE: begin
                if (enable_2x) begin
                    cnt_clear = 1'b1;
                    spp_load  = 1'b1;
                end
            end
            RUN: begin
                if (valid_in_2x) begin
                    wr_en     = 1'b1;
                    wr_last   = last_nat | ovf_hit;
                    ovf_event = ovf_hit;
                    cnt_clear = ovf_hit | last_nat;
                    spp_load  = last_nat & ~ovf_hit;
                end
            end
            OVERFLOW: begin
                if (fifo_empty) begin
                    cnt_clear = 1'b1;
                    spp_load  = enable_2x;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk2x or negedge reset_n_2x) begin
        if (!reset_n_2x) begin
            word_cnt <= 16'd0;
            spp_lat  <= 16'd1;
        end else begin
            if (cnt_clear)  word_cnt <= 16'd0;
            else if (wr_en) word_cnt <= word_cnt + 16'd1;
            if (spp_load)   spp_lat  <= spp_sel;
        end
    end

    // Storage array carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk2x) begin
        if (wr_en) mem[wr_ptr] <= {wr_last, adc_in_2x};
    end

    always_ff @(posedge clk2x or negedge reset_n_2x) begin
        if (!reset_n_2x) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            mem_cnt       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            if (wr_en)    wr_ptr <= wr_ptr + PTR_ONE;
            if (load_out) rd_ptr <= rd_ptr + PTR_ONE;
            mem_cnt <= mem_cnt + {{FIFO_AW{1'b0}}, wr_en} - {{FIFO_AW{1'b0}}, load_out};
            if (load_out) begin
                m_axis_tvalid                <= 1'b1;
                {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk2x or negedge reset_n_2x) begin
        if (!reset_n_2x) begin
            overflow_2x       <= 1'b0;
            overflow_count_2x <= 16'd0;
        end else begin
            overflow_2x <= ovf_event;
            if (clear_count_2x)
                overflow_count_2x <= 16'd0;
            else if (ovf_event && overflow_count_2x != 16'hFFFF)
                overflow_count_2x <= overflow_count_2x + 16'd1;
        end
    end

endmodule

// File: tb/tb_adc_axis_framer.sv
// Scoreboard bench for adc_axis_framer: a behavioural model predicts every FIFO
// write, the monitor pops and compares on each AXI transfer.
module tb_adc_axis_framer;

    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic         clk2x = 1'b0;
    logic         reset_n_2x;
    logic [127:0] adc_in_2x = '0;
    logic         valid_in_2x = 1'b0;
    logic         enable_2x = 1'b0;
    logic [15:0]  spp_2x = 16'd1;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b0;
    logic         overflow_2x;
    logic [15:0]  overflow_count_2x;
    logic         clear_count_2x = 1'b0;

    always #5 clk2x = ~clk2x;

    adc_axis_framer #(.FIFO_AW(FIFO_AW)) dut (
        .clk2x             (clk2x),
        .reset_n_2x        (reset_n_2x),
        .adc_in_2x         (adc_in_2x),
        .valid_in_2x       (valid_in_2x),
        .enable_2x         (enable_2x),
        .spp_2x            (spp_2x),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tready     (m_axis_tready),
        .overflow_2x       (overflow_2x),
        .overflow_count_2x (overflow_count_2x),
        .clear_count_2x    (clear_count_2x)
    );

    int vectors    = 0;
    int miscompares = 0;

    typedef enum {M_IDLE, M_RUN, M_OVF} mstate_t;

    logic [128:0] sb[$];
    bit           last_log[$];
    int           out_count  = 0;
    int           push_count = 0;

    mstate_t      ms;
    int           occ_m, wc_m, spp_m;
    logic         exp_ovf;
    logic [15:0]  exp_cnt;
    logic         stall_prev;
    logic [128:0] held;

    function automatic logic [127:0] mk(input int i);
        return {32'hDA7A_0000 + 32'(i), ~32'(i), 32'(i * 7), 32'h5A5A_5A5A ^ 32'(i)};
    endfunction

    function automatic int spp_eff(input logic [15:0] s);
        return (s == 16'd0) ? 1 : int'(s);
    endfunction

    // Reference model and output monitor share one process so both see pre-edge values.
    always @(posedge clk2x or negedge reset_n_2x) begin : model
        logic         xfer, nat, wr, lst, ovf;
        logic [128:0] got, exp;
        if (!reset_n_2x) begin
            sb.delete();
            ms         = M_IDLE;
            occ_m      = 0;
            wc_m       = 0;
            spp_m      = 1;
            exp_ovf    = 1'b0;
            exp_cnt    = 16'd0;
            stall_prev = 1'b0;
            held       = '0;
        end else begin
            if (stall_prev) begin
                vectors++;
                if (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== held) begin
                    miscompares++;
                    $display("[TB] FAIL stall_hold: got valid=%0b word=%h, need valid=1 word=%h",
                             m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, held);
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held       = {m_axis_tlast, m_axis_tdata};

            xfer = m_axis_tvalid && m_axis_tready;
            if (xfer) begin
                vectors++;
                got = {m_axis_tlast, m_axis_tdata};
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_output: got %h, need no transfer", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("[TB] FAIL output_word: got %h, need %h", got, exp);
                    end
                end
                out_count++;
                last_log.push_back(m_axis_tlast);
            end

            wr  = 1'b0;
            lst = 1'b0;
            ovf = 1'b0;
            case (ms)
                M_IDLE: if (enable_2x) begin
                    ms    = M_RUN;
                    wc_m  = 0;
                    spp_m = spp_eff(spp_2x);
                end
                M_RUN: if (valid_in_2x) begin
                    wr  = 1'b1;
                    nat = (wc_m == spp_m - 1);
                    if (occ_m == DEPTH - 2) begin
                        lst  = 1'b1;
                        ovf  = 1'b1;
                        ms   = M_OVF;
                        wc_m = 0;
                    end else begin
                        lst = nat;
                        if (nat) begin
                            wc_m  = 0;
                            spp_m = spp_eff(spp_2x);
                            if (!enable_2x) ms = M_IDLE;
                        end else begin
                            wc_m++;
                        end
                    end
                end
                M_OVF: if (occ_m == 0) begin
                    wc_m = 0;
                    if (enable_2x) begin
                        ms    = M_RUN;
                        spp_m = spp_eff(spp_2x);
                    end else begin
                        ms = M_IDLE;
                    end
                end
                default: ms = M_IDLE;
            endcase
            if (wr) begin
                sb.push_back({lst, adc_in_2x});
                push_count++;
            end
            occ_m   = occ_m + (wr ? 1 : 0) - (xfer ? 1 : 0);
            exp_ovf = ovf;
            if (clear_count_2x)                    exp_cnt = 16'd0;
            else if (ovf && exp_cnt != 16'hFFFF)   exp_cnt = exp_cnt + 16'd1;
        end
    end

    always @(negedge clk2x) begin
        if (reset_n_2x === 1'b1) begin
            vectors += 2;
            if (overflow_2x !== exp_ovf) begin
                miscompares++;
                $display("[TB] FAIL overflow_pulse: got %0b, need %0b", overflow_2x, exp_ovf);
            end
            if (overflow_count_2x !== exp_cnt) begin
                miscompares++;
                $display("[TB] FAIL overflow_count: got %0d, need %0d", overflow_count_2x, exp_cnt);
            end
        end
    end

    task automatic do_reset();
        reset_n_2x     = 1'b0;
        valid_in_2x    = 1'b0;
        enable_2x      = 1'b0;
        m_axis_tready  = 1'b0;
        clear_count_2x = 1'b0;
        spp_2x         = 16'd1;
        out_count      = 0;
        push_count     = 0;
        last_log.delete();
        repeat (2) @(negedge clk2x);
        reset_n_2x = 1'b1;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk2x);
            if (sb.size() == 0 && !m_axis_tvalid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        reset_n_2x = 1'b0;
        #1;
        vectors += 4;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_valid_last: got %0b/%0b, need 0/0", m_axis_tvalid, m_axis_tlast);
        end
        if (m_axis_tdata !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_tdata: got %h, need 0", m_axis_tdata);
        end
        if (overflow_2x !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_overflow: got %0b, need 0", overflow_2x);
        end
        if (overflow_count_2x !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_count: got %0d, need 0", overflow_count_2x);
        end
        @(negedge clk2x);
        reset_n_2x    = 1'b1;
        enable_2x     = 1'b1;
        spp_2x        = 16'd4;
        m_axis_tready = 1'b1;
        valid_in_2x   = 1'b1;
        adc_in_2x     = mk(100);
        @(negedge clk2x);
        adc_in_2x = mk(101);
        @(negedge clk2x);
        valid_in_2x = 1'b0;
        wait_drain(ok);
        vectors += 2;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL reset_drain_timeout: got pending=%0d, need 0", sb.size());
        end
        if (out_count != 1) begin
            miscompares++;
            $display("[TB] FAIL first_write_edge: got %0d words, need 1", out_count);
        end
    endtask

    task automatic test_basic_packets();
        bit ok;
        do_reset();
        spp_2x        = 16'd4;
        enable_2x     = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk2x);
        for (int i = 0; i < 12; i++) begin
            valid_in_2x = 1'b1;
            adc_in_2x   = mk(i);
            if (i == 1 || i == 2) begin
                vectors++;
                if (m_axis_tvalid !== (i == 2)) begin
                    miscompares++;
                    $display("[TB] FAIL first_tvalid_latency: got %0b at word %0d, need %0b",
                             m_axis_tvalid, i, (i == 2));
                end
            end
            @(negedge clk2x);
        end
        valid_in_2x = 1'b0;
        wait_drain(ok);
        vectors++;
        if (!ok || out_count != 12) begin
            miscompares++;
            $display("[TB] FAIL basic_count: got %0d words, need 12", out_count);
        end
        for (int j = 0; j < 12 && j < last_log.size(); j++) begin
            vectors++;
            if (last_log[j] != (j % 4 == 3)) begin
                miscompares++;
                $display("[TB] FAIL basic_tlast: word %0d got %0b, need %0b", j, last_log[j], (j % 4 == 3));
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        spp_2x    = 16'd8;
        enable_2x = 1'b1;
        @(negedge clk2x);
        for (int i = 0; i < 20; i++) begin
            valid_in_2x = 1'b1;
            adc_in_2x   = mk(200 + i);
            @(negedge clk2x);
        end
        valid_in_2x = 1'b0;
        vectors += 2;
        if (push_count != 15) begin
            miscompares++;
            $display("[TB] FAIL ovf_buffered: got %0d model writes, need 15", push_count);
        end
        if (overflow_count_2x !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL ovf_count_one: got %0d, need 1", overflow_count_2x);
        end
        m_axis_tready = 1'b1;
        wait_drain(ok);
        @(negedge clk2x);
        for (int i = 0; i < 8; i++) begin
            valid_in_2x = 1'b1;
            adc_in_2x   = mk(300 + i);
            @(negedge clk2x);
        end
        valid_in_2x = 1'b0;
        wait_drain(ok);
        vectors++;
        if (!ok || out_count != 23) begin
            miscompares++;
            $display("[TB] FAIL ovf_drain: got %0d words, need 23", out_count);
        end
        for (int j = 0; j < 23 && j < last_log.size(); j++) begin
            vectors++;
            if (last_log[j] != (j == 7 || j == 14 || j == 22)) begin
                miscompares++;
                $display("[TB] FAIL ovf_tlast: word %0d got %0b, need %0b",
                         j, last_log[j], (j == 7 || j == 14 || j == 22));
            end
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        do_reset();
        spp_2x        = 16'd6;
        enable_2x     = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk2x);
        for (int i = 0; i < 10; i++) begin
            valid_in_2x = 1'b1;
            adc_in_2x   = mk(400 + i);
            if (i == 3) enable_2x = 1'b0;
            @(negedge clk2x);
        end
        valid_in_2x = 1'b0;
        wait_drain(ok);
        vectors++;
        if (!ok || out_count != 6) begin
            miscompares++;
            $display("[TB] FAIL enable_drop_count: got %0d words, need 6", out_count);
        end
        for (int j = 0; j < 6 && j < last_log.size(); j++) begin
            vectors++;
            if (last_log[j] != (j == 5)) begin
                miscompares++;
                $display("[TB] FAIL enable_drop_tlast: word %0d got %0b, need %0b", j, last_log[j], (j == 5));
            end
        end
    endtask

    task automatic test_spp_change();
        bit         ok;
        logic [7:0] le;
        le = 8'hA7;
        do_reset();
        spp_2x        = 16'd0;
        enable_2x     = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk2x);
        for (int i = 0; i < 8; i++) begin
            spp_2x      = (i < 2) ? 16'd0 : (i < 4) ? 16'd3 : 16'd2;
            valid_in_2x = 1'b1;
            adc_in_2x   = mk(500 + i);
            @(negedge clk2x);
        end
        valid_in_2x = 1'b0;
        wait_drain(ok);
        vectors++;
        if (!ok || out_count != 8) begin
            miscompares++;
            $display("[TB] FAIL spp_count: got %0d words, need 8", out_count);
        end
        for (int j = 0; j < 8 && j < last_log.size(); j++) begin
            vectors++;
            if (last_log[j] != le[j]) begin
                miscompares++;
                $display("[TB] FAIL spp_tlast: word %0d got %0b, need %0b", j, last_log[j], le[j]);
            end
        end
    endtask

    task automatic test_clear();
        bit ok;
        do_reset();
        spp_2x         = 16'd16;
        enable_2x      = 1'b1;
        clear_count_2x = 1'b1;
        @(negedge clk2x);
        for (int i = 0; i < 16; i++) begin
            valid_in_2x = 1'b1;
            adc_in_2x   = mk(600 + i);
            @(negedge clk2x);
        end
        valid_in_2x = 1'b0;
        @(negedge clk2x);
        vectors++;
        if (overflow_count_2x !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL clear_wins: got %0d, need 0", overflow_count_2x);
        end
        clear_count_2x = 1'b0;
        m_axis_tready  = 1'b1;
        wait_drain(ok);
        @(negedge clk2x);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            valid_in_2x = 1'b1;
            adc_in_2x   = mk(700 + i);
            @(negedge clk2x);
        end
        valid_in_2x = 1'b0;
        vectors++;
        if (overflow_count_2x !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL count_after_clear: got %0d, need 1", overflow_count_2x);
        end
        clear_count_2x = 1'b1;
        @(negedge clk2x);
        clear_count_2x = 1'b0;
        vectors++;
        if (overflow_count_2x !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL clear_pulse: got %0d, need 0", overflow_count_2x);
        end
        m_axis_tready = 1'b1;
        wait_drain(ok);
    endtask

    task automatic test_random_stall();
        bit ok;
        do_reset();
        spp_2x    = 16'd16;
        enable_2x = 1'b1;
        @(negedge clk2x);
        for (int i = 0; i < 300; i++) begin
            valid_in_2x   = 1'b1;
            adc_in_2x     = mk(1000 + i);
            m_axis_tready = ($urandom_range(0, 1) == 1);
            @(negedge clk2x);
        end
        valid_in_2x   = 1'b0;
        m_axis_tready = 1'b1;
        wait_drain(ok);
        vectors += 2;
        if (!ok || out_count != push_count) begin
            miscompares++;
            $display("[TB] FAIL random_drain: got %0d words, need %0d", out_count, push_count);
        end
        if (exp_cnt == 16'd0 || overflow_count_2x !== exp_cnt) begin
            miscompares++;
            $display("[TB] FAIL random_ovf_count: got %0d, need %0d (nonzero)", overflow_count_2x, exp_cnt);
        end
    endtask

    task automatic test_reset_midpacket();
        bit ok;
        do_reset();
        spp_2x    = 16'd16;
        enable_2x = 1'b1;
        @(negedge clk2x);
        for (int k = 0; k < 3; k++) begin
            m_axis_tready = 1'b0;
            for (int i = 0; i < 16; i++) begin
                valid_in_2x = 1'b1;
                adc_in_2x   = mk(2000 + 16 * k + i);
                @(negedge clk2x);
            end
            valid_in_2x   = 1'b0;
            m_axis_tready = 1'b1;
            wait_drain(ok);
            @(negedge clk2x);
        end
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            valid_in_2x = 1'b1;
            adc_in_2x   = mk(3000 + i);
            @(negedge clk2x);
        end
        valid_in_2x = 1'b0;
        vectors += 2;
        if (overflow_count_2x !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_count: got %0d, need 3", overflow_count_2x);
        end
        if (m_axis_tvalid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_tvalid: got %0b, need 1", m_axis_tvalid);
        end
        reset_n_2x = 1'b0;
        #1;
        vectors += 2;
        if (m_axis_tvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_tvalid: got %0b, need 0", m_axis_tvalid);
        end
        if (overflow_count_2x !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_count: got %0d, need 0", overflow_count_2x);
        end
        out_count = 0;
        @(negedge clk2x);
        reset_n_2x    = 1'b1;
        enable_2x     = 1'b0;
        m_axis_tready = 1'b1;
        repeat (20) @(negedge clk2x);
        vectors++;
        if (out_count != 0) begin
            miscompares++;
            $display("[TB] FAIL stale_after_reset: got %0d words, need 0", out_count);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got no finish, need finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_n_2x = 1'b1;
        #1;
        test_reset();
        test_basic_packets();
        test_overflow();
        test_enable_drop();
        test_spp_change();
        test_clear();
        test_random_stall();
        test_reset_midpacket();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
